// File: rtl/o9_mem_pkg.sv
// Shared types, default widths and address helpers for the O9 RAM initiator.
package o9_mem_pkg;

  localparam int unsigned O9_DATA_W = 32;
  localparam int unsigned O9_ADDR_W = 16;
  localparam int unsigned O9_DEPTH  = 1024;
  localparam int unsigned O9_LEN_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } o9_state_e;

  // Next word address, wrapping from depth-1 back to 0.
  function automatic logic [31:0] addr_wrap_inc(input logic [31:0] addr,
                                                input logic [31:0] depth);
    return (addr >= depth - 32'd1) ? 32'd0 : addr + 32'd1;
  endfunction

endpackage

// File: rtl/o9_rd_slot.sv
// Single-entry valid/ready output register for read beats, with last flag.
module o9_rd_slot
  import o9_mem_pkg::*;
#(
  parameter int unsigned DATA_W = O9_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_last,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              free_c
);

  // Slot can accept a new beat when empty or being drained this cycle.
  assign free_c = !rd_valid || rd_ready;

  // Load takes priority; a drain without a load empties the slot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
    end else if (load) begin
      rd_valid <= 1'b1;
      rd_data  <= load_data;
      rd_last  <= load_last;
    end else if (rd_valid && rd_ready) begin
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
    end
  end

endmodule

// File: rtl/o9_mem_master.sv
// Burst read/write initiator for the O9 single-port word RAM.
// Optional beat statistics counters are enabled by defining O9_MEM_STATS_EN.
module o9_mem_master
  import o9_mem_pkg::*;
#(
  parameter int unsigned DATA_W = O9_DATA_W,
  parameter int unsigned ADDR_W = O9_ADDR_W,
  parameter int unsigned DEPTH  = O9_DEPTH,
  parameter int unsigned LEN_W  = O9_LEN_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic [31:0]       stat_rd,
  output logic [31:0]       stat_wr
);

  o9_state_e         state;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] data_hold;
  logic [LEN_W-1:0]  cnt;
  logic              wr_beat_c;
  logic              slot_free_c;
  logic              slot_load_c;
  logic [ADDR_W-1:0] next_addr_c;

  // Write beats go straight to the RAM port in the handshake cycle.
  assign wr_beat_c   = (state == WR) && wd_valid && wd_ready;
  assign slot_load_c = (state == RD) && slot_free_c;
  assign next_addr_c = ADDR_W'(addr_wrap_inc(32'(cur_addr), 32'(DEPTH)));

  // RAM port: active address during a burst, last value held while idle.
  assign mem_wren    = wr_beat_c;
  assign mem_address = (state == IDLE) ? addr_hold : cur_addr;
  assign mem_data    = wr_beat_c ? wd_data : data_hold;

  // Command, write-beat and read-load sequencing with registered handshakes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cur_addr  <= '0;
      cnt       <= '0;
      addr_hold <= '0;
      data_hold <= '0;
      req_ready <= 1'b1;
      wd_ready  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done      <= 1'b0;
      err       <= 1'b0;
      addr_hold <= mem_address;
      data_hold <= mem_data;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            cur_addr <= req_addr;
            cnt      <= req_len;
            if (32'(req_addr) >= DEPTH) begin
              err <= 1'b1;
            end else if (req_write) begin
              state     <= WR;
              req_ready <= 1'b0;
              wd_ready  <= 1'b1;
            end else begin
              state     <= RD;
              req_ready <= 1'b0;
            end
          end
        end
        WR: begin
          if (wr_beat_c) begin
            if (cnt == '0) begin
              state     <= IDLE;
              req_ready <= 1'b1;
              wd_ready  <= 1'b0;
              done      <= 1'b1;
            end else begin
              cnt      <= cnt - LEN_W'(1);
              cur_addr <= next_addr_c;
            end
          end
        end
        RD: begin
          if (slot_load_c) begin
            if (cnt == '0) begin
              state     <= IDLE;
              req_ready <= 1'b1;
              done      <= 1'b1;
            end else begin
              cnt      <= cnt - LEN_W'(1);
              cur_addr <= next_addr_c;
            end
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          wd_ready  <= 1'b0;
        end
      endcase
    end
  end

  o9_rd_slot #(
    .DATA_W(DATA_W)
  ) u_rd_slot (
    .clock    (clock),
    .reset    (reset),
    .load     (slot_load_c),
    .load_data(mem_q),
    .load_last(cnt == '0),
    .rd_ready (rd_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .free_c   (slot_free_c)
  );

`ifdef O9_MEM_STATS_EN
  logic rd_pop_c;
  assign rd_pop_c = rd_valid && rd_ready;

  // Saturating counters of read and write beat handshakes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_rd <= '0;
      stat_wr <= '0;
    end else begin
      if (rd_pop_c && (stat_rd != 32'hFFFF_FFFF)) stat_rd <= stat_rd + 32'd1;
      if (wr_beat_c && (stat_wr != 32'hFFFF_FFFF)) stat_wr <= stat_wr + 32'd1;
    end
  end
`else
  assign stat_rd = '0;
  assign stat_wr = '0;
`endif

endmodule

// File: tb/tb_o9_mem_master.sv
// Randomized and directed bench for o9_mem_master against a word-array model.
module tb_o9_mem_master;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int LW    = 8;
  localparam int DEPTH = 1024;

  logic          clock = 1'b0;
  logic          reset;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          wd_valid, wd_ready;
  logic [DW-1:0] wd_data;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic          done, err;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_data, mem_q;
  logic          mem_wren;
  logic [31:0]   stat_rd, stat_wr;

  always #5 clock = ~clock;

  o9_mem_master dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .done(done), .err(err),
    .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q),
    .stat_rd(stat_rd), .stat_wr(stat_wr)
  );

  // The RAM the controller drives (environment), and the golden word image.
  logic [DW-1:0] ram     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];
  assign mem_q = ram[int'(mem_address) % DEPTH];
  always @(posedge clock) if (mem_wren) ram[int'(mem_address) % DEPTH] <= mem_data;

  // Pulse counters, sampled on the rising edge (pre-update values).
  int done_cnt = 0, err_cnt = 0, wren_cnt = 0;
  always @(posedge clock) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (mem_wren) wren_cnt++;
  end

  int n_checks = 0, n_pass = 0;
  int exp_wr = 0, exp_rd = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int addr_of(input int base, input int i);
    return (base + i) % DEPTH;
  endfunction

  // Present a command at a falling edge; returns one falling edge after the handshake.
  task automatic send_cmd(input bit wr, input int addr, input int len);
    int t = 0;
    req_valid = 1'b1; req_write = wr; req_addr = AW'(addr); req_len = LW'(len);
    while (!req_ready && t < 100) begin @(negedge clock); t++; end
    if (t >= 100) check("cmd_timeout", 32'(t), 32'd0);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  task automatic write_burst(input int addr, input int len, input bit rnd, input logic [31:0] dbase);
    int d0 = done_cnt;
    logic [31:0] d;
    send_cmd(1'b1, addr, len);
    for (int i = 0; i <= len; i++) begin
      if (rnd) begin
        for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
          wd_valid = 1'b0; wd_data = $urandom; #1;
          check("wr_gap_wren", 32'(mem_wren), 32'd0);
          @(negedge clock);
        end
      end
      d = rnd ? $urandom : dbase + 32'(i);
      wd_valid = 1'b1; wd_data = d; #1;
      check("wd_ready", 32'(wd_ready), 32'd1);
      check("wr_wren", 32'(mem_wren), 32'd1);
      check("wr_addr", 32'(mem_address), 32'(addr_of(addr, i)));
      check("wr_data", mem_data, d);
      ref_mem[addr_of(addr, i)] = d;
      exp_wr++;
      @(negedge clock);
    end
    wd_valid = 1'b0;
    check("wr_done", 32'(done), 32'd1);
    check("wr_req_ready", 32'(req_ready), 32'd1);
    @(negedge clock);
    check("wr_done_once", 32'(done_cnt - d0), 32'd1);
  endtask

  // Consume len+1 beats of a read from base; mode 0 ready high, 1 toggling, 2 random.
  task automatic collect(input int base, input int len, input int mode,
                         output int first, output int last_t);
    int k = 0, t = 0;
    first = -1; last_t = -1;
    while (k <= len && t < 3000) begin
      case (mode)
        0: rd_ready = 1'b1;
        1: rd_ready = (t % 2 == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (rd_valid && rd_ready) begin
        check("rd_data", rd_data, ref_mem[addr_of(base, k)]);
        check("rd_last", 32'(rd_last), 32'(k == len));
        if (k == 0) first = t;
        last_t = t;
        k++; exp_rd++;
      end else if (rd_valid) begin
        check("rd_hold_addr", 32'(mem_address), 32'(addr_of(base, (k == len) ? len : k + 1)));
      end
      @(negedge clock); t++;
    end
    if (k <= len) check("rd_timeout", 32'(k), 32'(len + 1));
    rd_ready = 1'b0;
  endtask

  task automatic read_burst(input int addr, input int len, input int mode,
                            output int first, output int last_t);
    int d0 = done_cnt;
    send_cmd(1'b0, addr, len);
    collect(addr, len, mode, first, last_t);
    check("rd_done_once", 32'(done_cnt - d0), 32'd1);
    check("rd_slot_empty", 32'(rd_valid), 32'd0);
  endtask

  task automatic err_cmd(input bit wr, input int addr, input int len);
    int e0 = err_cnt, w0 = wren_cnt, v0 = done_cnt;
    send_cmd(wr, addr, len);
    wd_valid = 1'b1; wd_data = $urandom; #1;
    check("err_pulse", 32'(err), 32'd1);
    check("err_req_ready", 32'(req_ready), 32'd1);
    check("err_rd_valid", 32'(rd_valid), 32'd0);
    check("err_wd_ready", 32'(wd_ready), 32'd0);
    @(negedge clock);
    wd_valid = 1'b0;
    check("err_clear", 32'(err), 32'd0);
    check("err_once", 32'(err_cnt - e0), 32'd1);
    check("err_no_wren", 32'(wren_cnt - w0), 32'd0);
    check("err_no_done", 32'(done_cnt - v0), 32'd0);
  endtask

  task automatic check_stats(input string tag);
`ifdef O9_MEM_STATS_EN
    check({tag, "_stat_wr"}, stat_wr, 32'(exp_wr));
    check({tag, "_stat_rd"}, stat_rd, 32'(exp_rd));
`else
    check({tag, "_stat_wr"}, stat_wr, 32'd0);
    check({tag, "_stat_rd"}, stat_rd, 32'd0);
`endif
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_wd_ready"}, 32'(wd_ready), 32'd0);
    check({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    check({tag, "_rd_last"}, 32'(rd_last), 32'd0);
    check({tag, "_rd_data"}, rd_data, 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_wren"}, 32'(mem_wren), 32'd0);
    check({tag, "_addr"}, 32'(mem_address), 32'd0);
    check({tag, "_mdata"}, mem_data, 32'd0);
  endtask

  initial begin
    int first, last_t, w0, mism, a, l;
    for (int i = 0; i < DEPTH; i++) begin
      ram[i] = 32'hD00D_0000 ^ (32'(i) * 32'h0001_0101);
      ref_mem[i] = ram[i];
    end
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b0;
    @(negedge clock); @(negedge clock);
    check_reset_outputs("rst");
    reset = 1'b0;
    @(negedge clock);

    // Directed write: 4 beats of 0xA0..0xA3 at 5..8, wd_valid held high.
    w0 = wren_cnt;
    write_burst(5, 3, 1'b0, 32'hA0);
    check("wr4_wren_cycles", 32'(wren_cnt - w0), 32'd4);

    // Directed read back with rd_ready high: latency 1, one beat per cycle.
    read_burst(5, 3, 0, first, last_t);
    check("rd4_latency", 32'(first), 32'd1);
    check("rd4_throughput", 32'(last_t - first), 32'd3);
    check_stats("s12");

    // Read across the wrap point with toggling backpressure.
    read_burst(1022, 3, 1, first, last_t);

    // Out-of-range command, both directions.
    err_cmd(1'b0, 2000, 3);
    err_cmd(1'b1, DEPTH, 0);

    // New command accepted while the previous last beat still waits in the slot.
    send_cmd(1'b0, 40, 0);
    for (int t = 0; t < 10 && !rd_valid; t++) @(negedge clock);
    check("pend_valid", 32'(rd_valid), 32'd1);
    check("pend_last", 32'(rd_last), 32'd1);
    check("pend_req_ready", 32'(req_ready), 32'd1);
    send_cmd(1'b0, 41, 1);
    @(negedge clock);
    check("pend_held", rd_data, ref_mem[40]);
    rd_ready = 1'b1; #1;
    check("pend_pop_valid", 32'(rd_valid), 32'd1);
    check("pend_pop_data", rd_data, ref_mem[40]);
    if (rd_valid) exp_rd++;
    @(negedge clock);
    collect(41, 1, 0, first, last_t);

    // Randomized bursts.
    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 7) == 0) ? DEPTH + int'($urandom_range(0, 60000))
                                      : int'($urandom_range(0, DEPTH - 1));
      l = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 7));
      if (a >= DEPTH) err_cmd(1'($urandom_range(0, 1)), a, l);
      else if ($urandom_range(0, 1) == 1) write_burst(a, l, 1'b1, 32'd0);
      else read_burst(a, l, 2, first, last_t);
    end

    // Reset in the middle of a 4-beat write after two beats.
    send_cmd(1'b1, 0, 3);
    for (int i = 0; i < 2; i++) begin
      wd_valid = 1'b1; wd_data = 32'hBEEF_0000 + 32'(i);
      ref_mem[i] = wd_data;
      @(negedge clock);
    end
    reset = 1'b1; #1;
    check_reset_outputs("midrst");
    exp_wr = 0; exp_rd = 0;
    @(negedge clock);
    wd_valid = 1'b0; reset = 1'b0;
    @(negedge clock);
    check_stats("after_rst");

    write_burst(100, 1, 1'b1, 32'd0);
    read_burst(100, 1, 2, first, last_t);
    check_stats("final");

    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) mism++;
    check("ram_image", 32'(mism), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/o9_mem_master.md
Name: o9_mem_master

Overview:
Initiator-side controller for the O9 single-port word RAM: 16-bit address, 32-bit data, synchronous write on wren, combinational read data q.
- Accepts burst read/write commands from the O9 core or loader over a valid/ready handshake.
- Drives the RAM port, streams write beats in and read beats out with backpressure.
- Sits between the core's load/store path and the RAM instance.

Parameters:
DATA_W, 32, word width; equals RAM data width
ADDR_W, 16, RAM address port width
DEPTH, 1024, implemented words; legal addresses 0..DEPTH-1
LEN_W, 8, burst length field width; beats = req_len+1 (1..256)

Ports:
clock  in  1  single clock; all state updates on posedge
reset  in  1  asynchronous, active-high
req_valid  in  1  command valid
req_ready  out  1  command accepted when valid&ready
req_write  in  1  1=write burst, 0=read burst
req_addr  in  ADDR_W  burst base word address
req_len  in  LEN_W  beats minus one
wd_valid  in  1  write beat valid
wd_ready  out  1  write beat accepted when valid&ready
wd_data  in  DATA_W  write beat data
rd_valid  out  1  read beat valid
rd_ready  in  1  read beat consumed when valid&ready
rd_data  out  DATA_W  read beat data
rd_last  out  1  final beat of read burst
done  out  1  one-cycle pulse at burst completion
err  out  1  one-cycle pulse: rejected command (base >= DEPTH)
mem_address  out  ADDR_W  to RAM address
mem_data  out  DATA_W  to RAM data
mem_wren  out  1  to RAM wren
mem_q  in  DATA_W  from RAM q (same-cycle read data)

Behaviour:
- Reset (async, any state): FSM=IDLE; req_ready=1, wd_ready=0, rd_valid=0, rd_last=0, done=0, err=0, mem_wren=0, mem_address=0, mem_data=0, rd_data=0, beat counter=0. An in-flight burst is abandoned; partial writes already committed stay in RAM.
- States:
  - IDLE, req_ready=1: on handshake latch cur_addr=req_addr and cnt=req_len.
    - If req_addr >= DEPTH: pulse err next cycle, stay IDLE.
    - Else go to WR if req_write=1, otherwise RD.
  - WR, wd_ready=1: on wd handshake, in the same cycle mem_wren=1, mem_address=cur_addr, mem_data=wd_data. RAM commits at that edge.
    - If cnt==0: go to IDLE and pulse done next cycle.
    - Else cnt-1 and cur_addr+1.
  - RD: mem_address=cur_addr (mem_wren=0). The output slot loads when rd_valid==0 or rd_ready==1.
    - On load: rd_data<=mem_q, rd_valid<=1, rd_last<=(cnt==0).
    - If cnt==0: go to IDLE and pulse done with the last load.
    - Else cnt-1 and cur_addr+1.
    - If the slot is blocked, hold cur_addr and cnt.
- Slot clears on rd_valid&rd_ready with no new load.
- Read latency: first beat visible 1 cycle after entering RD. Full throughput: 1 beat/cycle when rd_ready is held high.
- Outside WR, mem_wren=0 always; mem_address holds its last value.
- Address wrap: cur_addr increments modulo DEPTH (DEPTH-1 -> 0); no err mid-burst.
- A new command may be accepted while the last read beat is still pending in the slot. The next RD load waits for the slot to free.
- wd_valid outside WR is ignored (wd_ready=0).

Optional Feature:
O9_MEM_STATS_EN: adds outputs stat_rd [31:0] and stat_wr [31:0].
- With the macro: counters of completed read beats (rd handshakes) and write beats (wd handshakes). Reset to 0, saturating at 32'hFFFFFFFF.
- Without the macro: the ports still exist, tied to 0, and no counter logic is present.

Decomposition:
- Package o9_mem_pkg holds the state enum {IDLE, WR, RD}, DATA_W/ADDR_W/DEPTH/LEN_W defaults and the address-wrap increment function.
- One natural sub-module: o9_rd_slot, the single-entry valid/ready output register with last flag.

Test Plan:
- Write burst addr=5, len=3, data 0xA0..0xA3, wd_valid held high -> mem_wren high for exactly 4 consecutive cycles at 5..8; done pulses once; RAM words 5..8 = 0xA0..0xA3.
- Read burst addr=5, len=3 with rd_ready=1 -> 4 beats 0xA0..0xA3 on consecutive cycles; rd_last only on 0xA3; done pulses once.
- Read addr=1022, len=3 with rd_ready toggling 1,0,1,0 -> beats from 1022,1023,0,1 in order; no beat lost or duplicated; address held while stalled.
- Command addr=2000 -> err pulses once; no mem_wren; no rd_valid; req_ready=1 the next cycle.
- Assert reset mid write burst after 2 of 4 beats -> all outputs at reset values immediately; words 0..1 written, words 2..3 unchanged.
- With O9_MEM_STATS_EN: after the first two scenarios, stat_wr=4 and stat_rd=4. Without it, both read 0.
